// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
//   arb_state_t : arbiter FSM states (IDLE = round-robin, LOCK = burst owner held)
//   rr_next     : modulo-n increment, safe for non-power-of-2 producer counts
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Rotating priority encoder.
//   req    : request vector, one bit per producer
//   rr_ptr : index holding highest priority this cycle
//   sel    : first requesting index at or after rr_ptr (wrapping); rr_ptr when none
//   any    : at least one request is set
module fifo_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   sel,
  output logic               any
);

  // Walk offsets from farthest to nearest so the nearest requester is the
  // last one written and therefore wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    sel = rr_ptr;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        sel = PTR_W'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ producers.
//   req_valid/req_last/req_data : per-producer beat, burst end, packed data
//   req_ready                   : beat from producer i accepted this cycle
//   fifo_wr_en/fifo_data_in     : muxed FIFO write port
//   fifo_full                   : back-pressure
//   fifo_wr_ack/fifo_overflow   : registered FIFO responses, checked here
//   grant_id/locked             : current selection and burst-lock status
//   err_clr/err_ack/err_overflow: sticky error reporting
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4,
  localparam int PTR_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [PTR_W-1:0]              grant_id,
  output logic                          locked,
  input  logic                          err_clr,
  output logic                          err_ack,
  output logic                          err_overflow
);

  arb_state_t       state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             ack_pend_q;
  logic             err_ack_q, err_ovf_q;

  logic [PTR_W-1:0] pick_sel;
  logic             pick_any;
  logic [PTR_W-1:0] sel;
  logic             xfer;

  fifo_arb_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req   (req_valid),
    .rr_ptr(rr_ptr_q),
    .sel   (pick_sel),
    .any   (pick_any)
  );

  assign sel = (state_q == LOCK) ? owner_q : pick_sel;

  // rst_n gates the handshake so nothing is written or accepted while the
  // arbiter is held in reset.
  assign xfer = ((state_q == LOCK) ? req_valid[owner_q] : pick_any)
                & ~fifo_full & rst_n;

  assign fifo_wr_en   = xfer;
  assign fifo_data_in = req_data[sel*FIFO_WIDTH +: FIFO_WIDTH];
  assign grant_id     = sel;
  assign locked       = (state_q == LOCK);
  assign err_ack      = err_ack_q;
  assign err_overflow = err_ovf_q;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      unique case (state_q)
        IDLE: begin
          if (req_last[sel] || MAX_BURST == 1) begin
            rr_ptr_d = PTR_W'(rr_next(int'(sel), NUM_REQ));
          end else begin
            state_d    = LOCK;
            owner_d    = sel;
            beat_cnt_d = CNT_W'(1);
          end
        end
        LOCK: begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          // Lock ends on the producer's last beat or when the burst cap is hit.
          if (req_last[owner_q] || int'(beat_cnt_q) + 1 == MAX_BURST) begin
            state_d  = IDLE;
            rr_ptr_d = PTR_W'(rr_next(int'(owner_q), NUM_REQ));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      ack_pend_q <= 1'b0;
      err_ack_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      ack_pend_q <= fifo_wr_en;

      // Set conditions take priority over the clear.
      if (ack_pend_q != fifo_wr_ack) err_ack_q <= 1'b1;
      else if (err_clr)              err_ack_q <= 1'b0;

      if (fifo_overflow) err_ovf_q <= 1'b1;
      else if (err_clr)  err_ovf_q <= 1'b0;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port (16-bit × 8 deep by default) among NUM_REQ producers. Each producer uses a valid/ready handshake; the arbiter muxes the granted producer onto the FIFO's wr_en/data_in. Back-pressure comes from the FIFO full flag. A lock mode keeps one producer granted for a multi-beat burst. The arbiter also checks the FIFO's wr_ack and overflow responses and reports sticky errors.

## Interface
- NUM_REQ, 4, number of producers (2..8)
- FIFO_WIDTH, 16, data width
- MAX_BURST, 4, maximum beats per locked grant (≥1; 1 disables lock)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  producer i has a beat
- req_last  in  NUM_REQ  beat from producer i ends its burst
- req_data  in  NUM_REQ*FIFO_WIDTH  packed; producer i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- req_ready  out  NUM_REQ  beat from producer i accepted this cycle
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  FIFO_WIDTH  FIFO write data
- fifo_full  in  1  FIFO full
- fifo_wr_ack  in  1  FIFO write acknowledge, registered by the FIFO
- fifo_overflow  in  1  FIFO overflow, registered by the FIFO
- grant_id  out  $clog2(NUM_REQ)  currently selected producer
- locked  out  1  arbiter is in LOCK
- err_clr  in  1  clears the sticky errors
- err_ack  out  1  sticky: wr_ack did not match the issued write
- err_overflow  out  1  sticky: the FIFO reported overflow

## Operation
- **State machine:** IDLE, LOCK. Registers: rr_ptr, owner, beat_cnt, ack_pend, and both error flags.
- **Selection, IDLE:** sel is the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- **Selection, LOCK:** sel = owner.
- **Transfer:** xfer = req_valid[sel] & !fifo_full.
  - fifo_wr_en = xfer.
  - req_ready[sel] = xfer; all other ready bits are 0.
  - fifo_data_in = req_data slice of sel (don't-care when xfer = 0).
- **IDLE with xfer:**
  - If req_last[sel] or MAX_BURST = 1: stay IDLE, rr_ptr <= sel+1 (mod NUM_REQ).
  - Otherwise: go to LOCK, owner <= sel, beat_cnt <= 1.
- **LOCK with xfer:** beat_cnt++.
  - If req_last[owner] or beat_cnt+1 = MAX_BURST: go to IDLE, rr_ptr <= owner+1.
- **LOCK without xfer** (owner not valid, or FIFO full): hold state. Other producers wait.
- **IDLE without xfer:** hold state.
- **Ack check:**
  - ack_pend <= fifo_wr_en.
  - Each cycle, ack_pend != fifo_wr_ack sets err_ack.
  - fifo_overflow = 1 sets err_overflow.
  - err_clr = 1 clears both flags; a set condition in the same cycle wins.
- **Width rules:**
  - rr_ptr and owner wrap modulo NUM_REQ, including non-power-of-2 values.
  - beat_cnt is $clog2(MAX_BURST+1) bits and never exceeds MAX_BURST.

## Timing
- Reset values: state IDLE, rr_ptr 0, owner 0, beat_cnt 0, ack_pend 0, err_ack 0, err_overflow 0, locked 0, grant_id 0.
- While rst_n = 0, fifo_wr_en and req_ready are forced to 0.
- Zero-latency combinational paths: req_valid/fifo_full → fifo_wr_en, req_ready. The FIFO latches data on the same edge.
- Throughput: one beat per cycle while !fifo_full.
- grant_id = sel; locked = (state == LOCK). Both are combinational from registered state and req_valid.
- fifo_full rising mid-burst: the lock is kept and the beat is retried the cycle full drops.
- Reset asserted mid-burst: returns to IDLE immediately. The partial burst is abandoned with no error flagged.
- ack_pend compares fifo_wr_ack one cycle after the write was issued.

## Structure
- **fifo_arb_pkg:** arb_state_t enum {IDLE, LOCK}; function rr_next(ptr, n) for the modulo increment.
- **Sub-module rr_pick:** rotating priority encoder. Inputs: req vector, rr_ptr. Outputs: sel, any.
- **Top:** FSM, counters, data mux, ack checker.

## Test plan
- **Fair rotation:** NUM_REQ=4, all valid, all req_last=1, FIFO never full → grants 0,1,2,3,0… with one beat per cycle; data matches the slice of each grant.
- **Burst lock:** MAX_BURST=4; producer 2 sends 6 beats (req_last on beat 6) while producer 0 is also valid → 2,2,2,2 (lock ends at MAX_BURST), then 3 skipped (not valid), then 0, then 2's remaining 2 beats.
- **Full back-pressure:** fifo_full=1 for 3 cycles during LOCK → fifo_wr_en=0 and req_ready=0, owner and beat_cnt unchanged; the beat is delivered the cycle full drops.
- **Owner stall:** locked owner 1 drops valid for 2 cycles while producer 3 is valid → producer 3 gets no ready; lock resumes when 1 returns.
- **Error flags:**
  - Drop fifo_wr_ack for one write → err_ack=1 the next cycle and stays set until err_clr.
  - Pulse fifo_overflow → err_overflow=1.
  - err_clr concurrent with a set condition → flag remains 1.
- **Async reset mid-LOCK (beat_cnt=2)** → immediately state IDLE, fifo_wr_en=0, rr_ptr=0; after release, producer 0 wins first.
